// File: rtl/decode_ctrl.sv
// Fetch/decode/execute/writeback sequencer for a small ARM-like core, with WFI sleep.
// Define DECODE_CTRL_COND_EXEC_EN to honour the cond field; otherwise every instruction runs as AL.
//
// state     | meaning
// ----------+-----------------------------------------------
// RST_IDLE  | one settle cycle after reset release
// FETCH     | fetch_req held until fetch_ack captures IR
// DECODE    | fields driven, cond evaluated and latched
// EXECUTE   | cu_execute pulse, undef_err for illegal op
// WRITEBACK | write pulses, pc update
// SLEEP     | WFI, waiting for irq
module decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    input  logic        in_n,
    input  logic        in_z,
    input  logic        in_c,
    input  logic        in_v,
    input  logic [31:0] alu_w_pc,
    input  logic [31:0] lr_in,
    input  logic        irq,
    output logic        cu_execute,
    output logic [4:0]  instrution,
    output logic        IMM,
    output logic        S,
    output logic [1:0]  stype,
    output logic [4:0]  imm_shift,
    output logic [11:0] imm_operand,
    output logic        br_L,
    output logic [23:0] br_offset_imm,
    output logic [3:0]  rd_idx,
    output logic [3:0]  rn_idx,
    output logic [3:0]  rm_idx,
    output logic [3:0]  rs_idx,
    output logic        rd_we,
    output logic        flags_we,
    output logic        lr_we,
    output logic        undef_err,
    output logic [31:0] pc,
    output logic        sleeping
);

    typedef enum logic [2:0] {
        RST_IDLE  = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        SLEEP     = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic        cond_ok;
    logic        cond_eval;
    logic [4:0]  op;
    logic        op_valid;
    logic        taken;
    logic        active;
    logic        unused_cond_inputs;

    assign op       = ir[27:23];
    assign op_valid = ~op[4];
    assign taken    = cond_ok & op_valid;

`ifdef DECODE_CTRL_COND_EXEC_EN
    always_comb begin
        cond_eval = 1'b0;
        case (ir[31:28])
            4'h0: cond_eval = in_z;
            4'h1: cond_eval = ~in_z;
            4'h2: cond_eval = in_c;
            4'h3: cond_eval = ~in_c;
            4'h4: cond_eval = in_n;
            4'h5: cond_eval = ~in_n;
            4'h6: cond_eval = in_v;
            4'h7: cond_eval = ~in_v;
            4'h8: cond_eval = in_c & ~in_z;
            4'h9: cond_eval = ~in_c | in_z;
            4'hA: cond_eval = (in_n == in_v);
            4'hB: cond_eval = (in_n != in_v);
            4'hC: cond_eval = ~in_z & (in_n == in_v);
            4'hD: cond_eval = in_z | (in_n != in_v);
            4'hE: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    end
    assign unused_cond_inputs = 1'b0;
`else
    assign cond_eval          = 1'b1;
    assign unused_cond_inputs = ^{in_n, in_z, in_c, in_v, ir[31:28]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RST_IDLE;
            pc      <= 32'd0;
            ir      <= 32'd0;
            cond_ok <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && fetch_ack)
                ir <= fetch_data;
            if (state == DECODE)
                cond_ok <= cond_eval;
            if (state == WRITEBACK) begin
                if (taken && (op == 5'h0C || op == 5'h0D))
                    pc <= alu_w_pc;
                else if (taken && op == 5'h0B)
                    pc <= lr_in;
                else
                    pc <= pc + 32'd4;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST_IDLE:  state_nxt = FETCH;
            FETCH:     if (fetch_ack) state_nxt = DECODE;
            DECODE:    state_nxt = EXECUTE;
            EXECUTE:   state_nxt = WRITEBACK;
            WRITEBACK: state_nxt = (taken && op == 5'h0A) ? SLEEP : FETCH;
            SLEEP:     if (irq) state_nxt = FETCH;
            default:   state_nxt = RST_IDLE;
        endcase
    end

    // Decoded bundle is held from DECODE through WRITEBACK and parked at zero elsewhere.
    assign active = (state == DECODE) || (state == EXECUTE) || (state == WRITEBACK);

    always_comb begin
        instrution    = 5'h1F;
        IMM           = 1'b0;
        S             = 1'b0;
        br_L          = 1'b0;
        stype         = 2'd0;
        imm_shift     = 5'd0;
        imm_operand   = 12'd0;
        br_offset_imm = 24'd0;
        rd_idx        = 4'd0;
        rn_idx        = 4'd0;
        rm_idx        = 4'd0;
        rs_idx        = 4'd0;
        if (active) begin
            instrution    = op_valid ? op : 5'h1F;
            IMM           = ir[22];
            S             = ir[21];
            br_L          = ir[21];
            stype         = ir[1:0];
            imm_shift     = ir[8:4];
            imm_operand   = ir[11:0];
            br_offset_imm = {3'b000, ir[20:0]};
            rd_idx        = ir[20:17];
            rn_idx        = ir[16:13];
            rm_idx        = ir[12:9];
            rs_idx        = ir[8:5];
        end
    end

    assign fetch_req  = (state == FETCH);
    assign fetch_addr = fetch_req ? pc : 32'd0;
    assign sleeping   = (state == SLEEP);
    assign cu_execute = (state == EXECUTE) && taken;
    assign undef_err  = (state == EXECUTE) && !op_valid;
    assign rd_we      = (state == WRITEBACK) && taken && (op <= 5'h08 || op == 5'h0E);
    assign flags_we   = (state == WRITEBACK) && taken && ir[21] && (op <= 5'h08);
    assign lr_we      = (state == WRITEBACK) && taken && ir[21] && (op == 5'h0C || op == 5'h0D);

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: stimulus serves directed instructions and queues
// expected per-instruction responses; a monitor pops them as the DUT fetches.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = 32'd0;
    logic        in_n = 1'b0, in_z = 1'b0, in_c = 1'b0, in_v = 1'b0;
    logic [31:0] alu_w_pc = 32'd0;
    logic [31:0] lr_in = 32'd0;
    logic        irq = 1'b0;
    logic        cu_execute;
    logic [4:0]  instrution;
    logic        IMM, S, br_L;
    logic [1:0]  stype;
    logic [4:0]  imm_shift;
    logic [11:0] imm_operand;
    logic [23:0] br_offset_imm;
    logic [3:0]  rd_idx, rn_idx, rm_idx, rs_idx;
    logic        rd_we, flags_we, lr_we, undef_err;
    logic [31:0] pc;
    logic        sleeping;

    decode_ctrl dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .alu_w_pc(alu_w_pc), .lr_in(lr_in), .irq(irq),
        .cu_execute(cu_execute), .instrution(instrution), .IMM(IMM), .S(S), .stype(stype),
        .imm_shift(imm_shift), .imm_operand(imm_operand), .br_L(br_L), .br_offset_imm(br_offset_imm),
        .rd_idx(rd_idx), .rn_idx(rn_idx), .rm_idx(rm_idx), .rs_idx(rs_idx),
        .rd_we(rd_we), .flags_we(flags_we), .lr_we(lr_we), .undef_err(undef_err),
        .pc(pc), .sleeping(sleeping)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          cu;
        logic [4:0]  ins;
        int          rd;
        int          fl;
        int          lr;
        int          und;
        logic [31:0] npc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] addr, input int cu, input logic [4:0] ins,
                                input int rd, input int fl, input int lr, input int und,
                                input logic [31:0] npc);
        exp_t e;
        e.addr = addr; e.cu = cu; e.ins = ins; e.rd = rd;
        e.fl = fl; e.lr = lr; e.und = und; e.npc = npc;
        return e;
    endfunction

    // Monitor: one accepted fetch starts a fixed DECODE/EXECUTE/WRITEBACK window.
    initial begin : monitor
        exp_t        e;
        int          n_cu, n_rd, n_fl, n_lr, n_und;
        logic [4:0]  ins_seen;
        forever begin
            @(negedge clk);
            if (fetch_req && fetch_ack) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_fetch: got addr 0x%0h expected none", fetch_addr);
                end else begin
                    e = q.pop_front();
                    chk("fetch_addr", fetch_addr, e.addr);
                    n_cu = 0; n_rd = 0; n_fl = 0; n_lr = 0; n_und = 0; ins_seen = 5'h00;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        n_cu  += int'(cu_execute);
                        n_rd  += int'(rd_we);
                        n_fl  += int'(flags_we);
                        n_lr  += int'(lr_we);
                        n_und += int'(undef_err);
                        if (i == 1) ins_seen = instrution;
                    end
                    chk("cu_execute_pulses", n_cu, e.cu);
                    chk("instrution", {27'd0, ins_seen}, {27'd0, e.ins});
                    chk("rd_we_pulses", n_rd, e.rd);
                    chk("flags_we_pulses", n_fl, e.fl);
                    chk("lr_we_pulses", n_lr, e.lr);
                    chk("undef_err_pulses", n_und, e.und);
                    @(posedge clk); #1;
                    chk("pc_after_wb", pc, e.npc);
                end
            end
        end
    end

    task automatic serve(input logic [31:0] instr, input int dly, input logic z,
                         input logic [31:0] wpc, input logic [31:0] lr, input exp_t e);
        int n = 0;
        while (!fetch_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!fetch_req) begin
            total++; bad++;
            $display("FAIL fetch_wait_timeout: got no fetch_req expected fetch at 0x%0h", e.addr);
            return;
        end
        repeat (dly) begin
            @(posedge clk); #1;
        end
        in_z       = z;
        alu_w_pc   = wpc;
        lr_in      = lr;
        fetch_data = instr;
        fetch_ack  = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        fetch_ack = 1'b0;
    endtask

    initial begin : stim
        int          n;
        logic [31:0] nx;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instrution", {27'd0, instrution}, 32'h1F);
        chk("rst_cu_execute", {31'd0, cu_execute}, 32'd0);
        chk("rst_sleeping", {31'd0, sleeping}, 32'd0);
        rst = 1'b0;

        serve(32'hE0400000, 1, 1'b0, 32'd0, 32'd0, mk(32'h0, 1, 5'h00, 1, 0, 0, 0, 32'h4));
        serve(32'hE0600000, 0, 1'b0, 32'd0, 32'd0, mk(32'h4, 1, 5'h00, 1, 1, 0, 0, 32'h8));
        serve(32'hE5000000, 0, 1'b0, 32'd0, 32'd0, mk(32'h8, 1, 5'h0A, 0, 0, 0, 0, 32'hC));

        n = 0;
        while (!sleeping && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sleep_entered", {31'd0, sleeping}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("sleep_hold", {31'd0, sleeping}, 32'd1);
            chk("sleep_no_fetch", {31'd0, fetch_req}, 32'd0);
        end
        irq = 1'b1;
        @(posedge clk); #1;
        irq = 1'b0;
        chk("wake_fetch_req", {31'd0, fetch_req}, 32'd1);

        serve(32'h06A00010, 0, 1'b1, 32'h100, 32'd0, mk(32'hC, 1, 5'h0D, 0, 0, 1, 0, 32'h100));
`ifdef DECODE_CTRL_COND_EXEC_EN
        nx = 32'h104;
        serve(32'h06A00010, 0, 1'b0, 32'h200, 32'd0, mk(32'h100, 0, 5'h0D, 0, 0, 0, 0, nx));
`else
        nx = 32'h200;
        serve(32'h06A00010, 0, 1'b0, 32'h200, 32'd0, mk(32'h100, 1, 5'h0D, 0, 0, 1, 0, nx));
`endif
        serve(32'hEA800000, 0, 1'b0, 32'd0, 32'd0, mk(nx, 0, 5'h1F, 0, 0, 0, 1, nx + 32'd4));
        serve(32'hE5800000, 0, 1'b0, 32'd0, 32'h40, mk(nx + 32'd4, 1, 5'h0B, 0, 0, 0, 0, 32'h40));
        serve(32'hE6000000, 0, 1'b0, 32'hFFFFFFFC, 32'd0, mk(32'h40, 1, 5'h0C, 0, 0, 0, 0, 32'hFFFFFFFC));
        serve(32'hE0400000, 0, 1'b0, 32'd0, 32'd0, mk(32'hFFFFFFFC, 1, 5'h00, 1, 0, 0, 0, 32'h0));
        serve(32'hE7000000, 0, 1'b0, 32'd0, 32'd0, mk(32'h0, 1, 5'h0E, 1, 0, 0, 0, 32'h4));
`ifdef DECODE_CTRL_COND_EXEC_EN
        serve(32'hF0400000, 0, 1'b0, 32'd0, 32'd0, mk(32'h4, 0, 5'h00, 0, 0, 0, 0, 32'h8));
`else
        serve(32'hF0400000, 0, 1'b0, 32'd0, 32'd0, mk(32'h4, 1, 5'h00, 1, 0, 0, 0, 32'h8));
`endif

        // Reset while FETCH is waiting; acks during reset must not be taken.
        n = 0;
        while (!fetch_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midfetch_waiting", {31'd0, fetch_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_instrution", {27'd0, instrution}, 32'h1F);
        chk("midrst_cu_execute", {31'd0, cu_execute}, 32'd0);
        fetch_data = 32'hE0400000;
        fetch_ack  = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("late_ack_ignored", {31'd0, fetch_req}, 32'd0);
        end
        rst       = 1'b0;
        fetch_ack = 1'b0;
        serve(32'hE0400000, 0, 1'b0, 32'd0, 32'd0, mk(32'h0, 1, 5'h00, 1, 0, 0, 0, 32'h4));

        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have fetch_req out 1, fetch_addr out 32, fetch_ack in 1, fetch_data in 32: instruction fetch handshake.
REQ-004 SHALL have in_n, in_z, in_c, in_v in 1 each: current flags; alu_w_pc in 32: branch target from ALU; lr_in in 32: link register; irq in 1: wake from WFI.
REQ-005 SHALL have cu_execute out 1, instrution out 5, IMM out 1, S out 1, stype out 2, imm_shift out 5, imm_operand out 12, br_L out 1, br_offset_imm out 24: ALU control bundle.
REQ-006 SHALL have rd_idx, rn_idx, rm_idx, rs_idx out 4 each: register-file indices.
REQ-007 SHALL have rd_we, flags_we, lr_we, undef_err out 1 each (single-cycle pulses); pc out 32: program counter; sleeping out 1.

Function
REQ-008 SHALL decode IR: cond [31:28], op [27:23], IMM [22], S/L [21], Rd [20:17], Rn [16:13], Rm [12:9], Rs [8:5], imm_shift [8:4], stype [1:0], imm_operand [11:0], br_offset_imm = {3'b000, IR[20:0]}.
REQ-009 SHALL implement FSM states RST_IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, SLEEP.
REQ-010 RST_IDLE SHALL last exactly one cycle after rst deasserts, then go to FETCH.
REQ-011 FETCH SHALL hold fetch_req=1 and fetch_addr=pc until fetch_ack=1; at that edge IR<=fetch_data and state->DECODE; fetch_ack outside FETCH SHALL be ignored.
REQ-012 DECODE SHALL last one cycle: drive decoded fields, evaluate cond against flags (ARM encodings EQ..LE, 1110=AL, 1111=never).
REQ-013 op 0x00-0x0F SHALL be valid; any other op SHALL drive instrution=0x1F, suppress cu_execute, pulse undef_err in EXECUTE, and advance pc by 4.
REQ-014 EXECUTE SHALL assert cu_execute for exactly one cycle iff cond passes and op valid; ALU bundle SHALL stay stable DECODE through WRITEBACK.
REQ-015 WRITEBACK (one cycle) SHALL: pulse rd_we for ops 0x00-0x08 and 0x0E except CMP-class none; pulse flags_we iff S=1 and op 0x00-0x08; pulse lr_we iff op in {0x0C,0x0D} and L=1.
REQ-016 pc update in WRITEBACK: B/BX taken -> alu_w_pc; ERET taken -> lr_in; otherwise pc+4, wrapping modulo 2^32.
REQ-017 Condition fail SHALL suppress cu_execute and all write pulses; pc<=pc+4.
REQ-018 WFI (0x0A) taken SHALL go WRITEBACK->SLEEP with pc+4; SLEEP holds sleeping=1 until irq=1, then FETCH next cycle; irq outside SLEEP ignored.
REQ-019 Minimum instruction latency SHALL be 4 cycles (ack in first FETCH cycle).

Reset
REQ-020 rst=1 SHALL, at any state including mid-fetch, force RST_IDLE, pc=0, IR=0, instrution=0x1F, all pulses, fetch_req, sleeping and remaining outputs 0 at next edge.
REQ-021 A pending fetch_ack during reset SHALL be discarded; fetch restarts at address 0.

Configuration
REQ-022 Macro DECODE_CTRL_COND_EXEC_EN defined: cond evaluated per REQ-012.
REQ-023 Macro undefined: cond field ignored, every instruction treated as AL.

Verification
REQ-024 Reset release, ack on 2nd FETCH cycle with 0xE0400000 (ADD AL) -> fetch_addr=0, cu_execute one pulse, instrution=0x00, rd_we pulse, pc=4.
REQ-025 IR=0x06A00010 (B, EQ, L=1) with in_z=1, alu_w_pc=0x100 -> lr_we pulse, pc=0x100; same with in_z=0 -> no cu_execute, pc+4.
REQ-026 IR op=0x15 -> instrution=0x1F, undef_err pulse, no cu_execute, pc+4.
REQ-027 WFI AL at pc=8 -> sleeping=1, fetch_req=0 for 10 cycles; irq=1 -> FETCH at 0xC.
REQ-028 rst asserted while FETCH waiting on ack -> outputs zero next edge; late ack ignored; refetch from 0.
REQ-029 pc=0xFFFFFFFC, ADD AL -> pc wraps to 0x00000000.
